// File: rtl/output_drain_ctrl.sv
// rtl/output_drain_ctrl.sv - drains one accumulated tile from the column shifters into the output buffer

`ifndef ARRAYHEIGHT
`define ARRAYHEIGHT 4
`endif
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 32
`endif

module output_drain_ctrl #(
    parameter int ROWS = `ARRAYHEIGHT,
    parameter int COLS = `ARRAYWIDTH,
    parameter int DW   = `OUTPUT_BUF_DATASIZE,
    parameter int AW   = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [AW-1:0]        tile_base_addr_i,
    input  logic [COLS*DW-1:0]   col_data_i,
    output logic                 shift_en_o,
    output logic                 acc_clear_o,
    output logic                 wr_valid_o,
    input  logic                 wr_ready_i,
    output logic [AW-1:0]        wr_addr_o,
    output logic [COLS*DW-1:0]   wr_data_o,
    output logic                 busy_o,
    output logic                 done_o
);

    // Row counter must hold 0..ROWS-1; keep at least one bit for ROWS==1.
    localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e             state_q;
    logic [RCW-1:0]     row_cnt_q;
    logic [RCW-1:0]     row_cnt_d;
    logic [AW-1:0]      addr_q;
    logic [AW-1:0]      addr_d;
    logic [COLS*DW-1:0] row_q;
    logic               shift_en_q;
    logic               acc_clear_q;
    logic               wr_valid_q;
    logic               done_q;
    logic               last_row;
    logic               handshake;

    // Next row index / address; the address wraps naturally at 2^AW.
    always_comb begin
        row_cnt_d = row_cnt_q + 1'b1;
        addr_d    = addr_q + 1'b1;
        last_row  = (row_cnt_q == RCW'(ROWS - 1));
        handshake = wr_valid_q && wr_ready_i;
    end

    // Drain sequencer: all control outputs are registered alongside the state,
    // so each pulse is visible exactly during the state it belongs to.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            addr_q      <= '0;
            row_q       <= '0;
            shift_en_q  <= 1'b0;
            acc_clear_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Pulses default low; only the transitions below raise them.
            shift_en_q  <= 1'b0;
            acc_clear_q <= 1'b0;
            done_q      <= 1'b0;

            if (abort_i && (state_q != IDLE)) begin
                // Cancel wins over any handshake or completion this cycle.
                state_q    <= IDLE;
                wr_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        wr_valid_q <= 1'b0;
                        if (start_i) begin
                            addr_q     <= tile_base_addr_i;
                            row_cnt_q  <= '0;
                            shift_en_q <= 1'b1;
                            state_q    <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        // The shifter advances on this same edge, so the
                        // current head element is captured here.
                        row_q      <= col_data_i;
                        wr_valid_q <= 1'b1;
                        state_q    <= WRITE;
                    end
                    WRITE: begin
                        if (handshake) begin
                            wr_valid_q <= 1'b0;
                            if (last_row) begin
                                done_q      <= 1'b1;
                                acc_clear_q <= 1'b1;
                                state_q     <= DONE;
                            end else begin
                                row_cnt_q  <= row_cnt_d;
                                addr_q     <= addr_d;
                                shift_en_q <= 1'b1;
                                state_q    <= CAPTURE;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q    <= IDLE;
                        wr_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign shift_en_o  = shift_en_q;
    assign acc_clear_o = acc_clear_q;
    assign wr_valid_o  = wr_valid_q;
    assign wr_addr_o   = addr_q;
    assign wr_data_o   = row_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_output_drain_ctrl.sv
// tb/tb_output_drain_ctrl.sv - randomized self-checking bench for output_drain_ctrl

module tb_output_drain_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int WW   = COLS * DW;

    logic          clk_i;
    logic          rst_ni;
    logic          start_i;
    logic          abort_i;
    logic [AW-1:0] tile_base_addr_i;
    logic [WW-1:0] col_data_i;
    logic          shift_en_o;
    logic          acc_clear_o;
    logic          wr_valid_o;
    logic          wr_ready_i;
    logic [AW-1:0] wr_addr_o;
    logic [WW-1:0] wr_data_o;
    logic          busy_o;
    logic          done_o;

    int vectors;
    int miscompares;

    output_drain_ctrl #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .tile_base_addr_i (tile_base_addr_i),
        .col_data_i       (col_data_i),
        .shift_en_o       (shift_en_o),
        .acc_clear_o      (acc_clear_o),
        .wr_valid_o       (wr_valid_o),
        .wr_ready_i       (wr_ready_i),
        .wr_addr_o        (wr_addr_o),
        .wr_data_o        (wr_data_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] rand_row();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, WW'(busy_o), '0);
        check({tag, " wr_valid"}, WW'(wr_valid_o), '0);
        check({tag, " shift_en"}, WW'(shift_en_o), '0);
        check({tag, " done"}, WW'(done_o), '0);
        check({tag, " acc_clear"}, WW'(acc_clear_o), '0);
        check({tag, " wr_addr"}, WW'(wr_addr_o), '0);
        check({tag, " wr_data"}, wr_data_o, '0);
    endtask

    // One drain: the bench plays the column shifters (a list of rows that
    // advances on shift_en) and the output buffer (wr_ready, with an optional
    // stall on one row). Expectations come from the tile's rules: row i goes
    // to base+i mod 2^AW, ROWS shifts, done at 2*ROWS+1 cycles plus stalls.
    task automatic run_drain(input string name, input logic [AW-1:0] b, input int s_row,
                             input int s_len, input int ab_row, input bit poke);
        logic [WW-1:0] rows [ROWS];
        logic [AW-1:0] got_addr [$];
        logic [WW-1:0] got_data [$];
        logic [AW-1:0] p_addr;
        logic [WW-1:0] p_data;
        int  sh_idx = 0, n_shift = 0, n_done = 0, n_acc = 0;
        int  done_cyc = -1, acc_cyc = -1, stall_cnt = 0, cyc = 0, end_cyc = -1;
        int  exp_w, exp_shift, exp_stall;
        bit  prev_stall = 0, fin = 0, overlap = 0, coin;
        for (int i = 0; i < ROWS; i++) rows[i] = rand_row();
        coin = 1'($urandom_range(0, 1));
        p_addr = '0;
        p_data = '0;
        while (!fin) begin
            @(negedge clk_i);
            start_i          = (cyc == 0) || (poke && (cyc == 3 || cyc == 6));
            tile_base_addr_i = (cyc == 0) ? b : AW'($urandom());
            col_data_i       = (sh_idx < ROWS) ? rows[sh_idx] : rand_row();
            if (wr_valid_o && got_addr.size() == s_row && stall_cnt < s_len) begin
                wr_ready_i = 1'b0;
                stall_cnt++;
            end else begin
                wr_ready_i = wr_valid_o ? 1'b1 : 1'($urandom_range(0, 1));
            end
            abort_i = (cyc == 0 && coin) ||
                      (ab_row >= 0 && wr_valid_o && wr_ready_i && got_addr.size() == ab_row);
            if (prev_stall) begin
                check({name, " stall wr_valid"}, WW'(wr_valid_o), WW'(1));
                check({name, " stall wr_addr"}, WW'(wr_addr_o), WW'(p_addr));
                check({name, " stall wr_data"}, wr_data_o, p_data);
            end
            prev_stall = wr_valid_o && !wr_ready_i;
            p_addr = wr_addr_o;
            p_data = wr_data_o;
            if (shift_en_o && wr_valid_o) overlap = 1;
            if (shift_en_o) begin
                n_shift++;
                sh_idx++;
            end
            if (done_o) begin
                n_done++;
                done_cyc = cyc;
            end
            if (acc_clear_o) begin
                n_acc++;
                acc_cyc = cyc;
            end
            if (wr_valid_o && wr_ready_i && !abort_i) begin
                got_addr.push_back(wr_addr_o);
                got_data.push_back(wr_data_o);
            end
            if (cyc > 0 && !busy_o) begin
                fin = 1;
                end_cyc = cyc;
            end else if (cyc >= 60) begin
                fin = 1;
                check({name, " timeout busy"}, WW'(busy_o), '0);
            end
            cyc++;
        end
        start_i = 1'b0;
        abort_i = 1'b0;

        exp_w     = (ab_row >= 0) ? ab_row : ROWS;
        exp_shift = (ab_row >= 0) ? ab_row + 1 : ROWS;
        exp_stall = (s_row >= 0 && (ab_row < 0 || s_row <= ab_row)) ? s_len : 0;
        check({name, " write count"}, WW'(got_addr.size()), WW'(exp_w));
        for (int i = 0; i < exp_w && i < got_addr.size(); i++) begin
            check($sformatf("%s addr[%0d]", name, i), WW'(got_addr[i]), WW'(AW'(b + AW'(i))));
            check($sformatf("%s data[%0d]", name, i), got_data[i], rows[i]);
        end
        check({name, " shift count"}, WW'(n_shift), WW'(exp_shift));
        check({name, " shift during wr_valid"}, WW'(overlap), '0);
        check({name, " done count"}, WW'(n_done), WW'((ab_row >= 0) ? 0 : 1));
        check({name, " acc_clear count"}, WW'(n_acc), WW'((ab_row >= 0) ? 0 : 1));
        if (ab_row < 0) begin
            check({name, " done cycle"}, WW'(done_cyc), WW'(2 * ROWS + 1 + exp_stall));
            check({name, " acc_clear cycle"}, WW'(acc_cyc), WW'(done_cyc));
            check({name, " idle cycle"}, WW'(end_cyc), WW'(2 * ROWS + 2 + exp_stall));
        end else begin
            check({name, " idle cycle"}, WW'(end_cyc), WW'(2 * ab_row + 3 + exp_stall));
        end
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst_ni           = 1'b0;
        start_i          = 1'b0;
        abort_i          = 1'b0;
        tile_base_addr_i = '0;
        col_data_i       = '0;
        wr_ready_i       = 1'b0;

        // Reset state, then idle with stray aborts: nothing may start.
        repeat (2) @(negedge clk_i);
        check_all_zero("reset");
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            abort_i    = 1'($urandom_range(0, 1));
            wr_ready_i = 1'($urandom_range(0, 1));
            check("idle busy", WW'(busy_o), '0);
            check("idle wr_valid", WW'(wr_valid_o), '0);
        end
        abort_i = 1'b0;

        run_drain("basic", 10'h010, -1, 0, -1, 1'b0);
        run_drain("backpressure", 10'h010, 1, 3, -1, 1'b0);
        run_drain("wrap", 10'h3FE, -1, 0, -1, 1'b0);
        run_drain("start_busy", 10'h120, 2, 2, -1, 1'b1);
        run_drain("after_done", 10'h200, -1, 0, -1, 1'b0);

        // Reset asserted mid-drain during the write of row 2.
        for (int c = 0; c < 7; c++) begin
            @(negedge clk_i);
            start_i          = (c == 0);
            tile_base_addr_i = 10'h155;
            col_data_i       = rand_row();
            wr_ready_i       = 1'b1;
        end
        check("pre-reset wr_valid", WW'(wr_valid_o), WW'(1));
        check("pre-reset wr_addr", WW'(wr_addr_o), WW'(10'h157));
        #1 rst_ni = 1'b0;
        #1 check_all_zero("async reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post-reset busy", WW'(busy_o), '0);
        run_drain("post_reset", 10'h2A0, -1, 0, -1, 1'b0);

        run_drain("abort_row3", 10'h050, -1, 0, 3, 1'b0);
        run_drain("after_abort", 10'h060, -1, 0, -1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            int ab;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, ROWS - 1)) : -1;
            run_drain($sformatf("random%0d", k), AW'($urandom()),
                      int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, 4)),
                      ab, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
